w_data_router: RTL and testbench

- Consumer end of the write-data ordering queue inside the AXI4 interconnect.
- Reads the queue head (Master_Valid, Write_Data_Master) and locks the W channel onto that master.
- Forwards that master's W beats through a one-entry registered stage to the slave port.
- Returns a one-cycle Write_Data_Finsh pulse to the queue once the WLAST beat is accepted by the slave.

---
 rtl/w_data_router.sv | 161 ++++++++++++++++
 tb/tb_w_data_router.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_data_router.sv
// W-channel router: locks onto the master at the write-order queue head, forwards its beats
// through a one-entry register stage to the slave, and pulses Write_Data_Finsh after WLAST.
module w_data_router #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              Master_Valid,
    input  logic [ID_WIDTH-1:0]               Write_Data_Master,
    input  logic                              Is_Master_Part_Of_Split,
    output logic                              Write_Data_Finsh,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] S_WDATA,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic [NUM_MASTERS-1:0]            S_WLAST,
    input  logic [NUM_MASTERS-1:0]            S_WVALID,
    output logic [NUM_MASTERS-1:0]            S_WREADY,
    output logic [DATA_WIDTH-1:0]             M_WDATA,
    output logic [DATA_WIDTH/8-1:0]           M_WSTRB,
    output logic                              M_WLAST,
    output logic                              M_WVALID,
    input  logic                              M_WREADY,
    output logic                              Split_Active,
    output logic [CNT_WIDTH-1:0]              Beat_Count
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StData, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ID_WIDTH-1:0]     sel_q, sel_d;
    logic                    split_q, split_d;
    logic                    last_taken_q, last_taken_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
    logic [StrbWidth-1:0]    m_wstrb_q, m_wstrb_d;
    logic                    m_wlast_q, m_wlast_d;
    logic                    m_wvalid_q, m_wvalid_d;

    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [StrbWidth-1:0]    sel_wstrb;
    logic                    sel_wlast;
    logic                    sel_wvalid;
    logic                    head_ok;
    logic                    accept_ok;
    logic                    load;
    logic                    drain;

    // Select the granted master's W signals and steer ready back to it only.
    always_comb begin
        sel_wdata  = '0;
        sel_wstrb  = '0;
        sel_wlast  = 1'b0;
        sel_wvalid = 1'b0;
        S_WREADY   = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (sel_q == ID_WIDTH'(i)) begin
                sel_wdata   = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb   = S_WSTRB[i*StrbWidth +: StrbWidth];
                sel_wlast   = S_WLAST[i];
                sel_wvalid  = S_WVALID[i];
                S_WREADY[i] = accept_ok;
            end
        end
    end

    // An out-of-range head index is never granted.
    assign head_ok   = Master_Valid && (32'(Write_Data_Master) < NUM_MASTERS);
    // Stage can take a beat when empty or draining this cycle; closed once WLAST is in.
    assign accept_ok = (state_q == StData) && (!m_wvalid_q || M_WREADY) && !last_taken_q;
    assign load      = accept_ok && sel_wvalid;
    assign drain     = m_wvalid_q && M_WREADY;

    // Next-state logic for the grant FSM and the output stage.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        split_d      = split_q;
        last_taken_d = last_taken_q;
        cnt_d        = cnt_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        m_wlast_d    = m_wlast_q;
        m_wvalid_d   = m_wvalid_q;
        unique case (state_q)
            StIdle: begin
                if (head_ok) begin
                    sel_d   = Write_Data_Master;
                    split_d = Is_Master_Part_Of_Split;
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (load) begin
                    m_wdata_d  = sel_wdata;
                    m_wstrb_d  = sel_wstrb;
                    m_wlast_d  = sel_wlast;
                    m_wvalid_d = 1'b1;
                    if (sel_wlast) begin
                        last_taken_d = 1'b1;
                    end
                end else if (drain) begin
                    m_wvalid_d = 1'b0;
                end
                if (drain) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (m_wlast_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_taken_d = 1'b0;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output-stage registers; reset drops any in-flight beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            split_q      <= 1'b0;
            last_taken_q <= 1'b0;
            cnt_q        <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            m_wlast_q    <= 1'b0;
            m_wvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            split_q      <= split_d;
            last_taken_q <= last_taken_d;
            cnt_q        <= cnt_d;
            m_wdata_q    <= m_wdata_d;
            m_wstrb_q    <= m_wstrb_d;
            m_wlast_q    <= m_wlast_d;
            m_wvalid_q   <= m_wvalid_d;
        end
    end

    assign Write_Data_Finsh = (state_q == StDone);
    assign M_WDATA          = m_wdata_q;
    assign M_WSTRB          = m_wstrb_q;
    assign M_WLAST          = m_wlast_q;
    assign M_WVALID         = m_wvalid_q;
    assign Split_Active     = split_q;
    assign Beat_Count       = cnt_q;

endmodule

// File: tb/tb_w_data_router.sv
// Scoreboard bench for w_data_router: stimulus pushes expected slave beats, a negedge monitor
// pops and compares on every slave handshake and watches Finsh timing, hold and isolation.
module tb_w_data_router;

    localparam int NM = 2;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    logic            clk;
    logic            reset;
    logic            Master_Valid;
    logic [IW-1:0]   Write_Data_Master;
    logic            Is_Master_Part_Of_Split;
    logic            Write_Data_Finsh;
    logic [NM*DW-1:0] S_WDATA;
    logic [NM*SW-1:0] S_WSTRB;
    logic [NM-1:0]   S_WLAST;
    logic [NM-1:0]   S_WVALID;
    logic [NM-1:0]   S_WREADY;
    logic [DW-1:0]   M_WDATA;
    logic [SW-1:0]   M_WSTRB;
    logic            M_WLAST;
    logic            M_WVALID;
    logic            M_WREADY;
    logic            Split_Active;
    logic [7:0]      Beat_Count;

    // Narrow-counter instance sharing all inputs, used for the saturation checks.
    logic            finsh_b;
    logic [NM-1:0]   s_wready_b;
    logic [DW-1:0]   m_wdata_b;
    logic [SW-1:0]   m_wstrb_b;
    logic            m_wlast_b;
    logic            m_wvalid_b;
    logic            split_b;
    logic [1:0]      beat_count_b;

    int    n_cmp = 0;
    int    n_err = 0;
    int    fin_cnt = 0;
    int    exp_sel = 0;
    logic  exp_sel_vld = 1'b0;
    beat_t exp_q[$];

    w_data_router #(
        .NUM_MASTERS(NM), .ID_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(8)
    ) u_dut (
        .clk(clk), .reset(reset), .Master_Valid(Master_Valid),
        .Write_Data_Master(Write_Data_Master),
        .Is_Master_Part_Of_Split(Is_Master_Part_Of_Split),
        .Write_Data_Finsh(Write_Data_Finsh), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .M_WDATA(M_WDATA),
        .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .Split_Active(Split_Active), .Beat_Count(Beat_Count)
    );

    w_data_router #(
        .NUM_MASTERS(NM), .ID_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(2)
    ) u_dut_sat (
        .clk(clk), .reset(reset), .Master_Valid(Master_Valid),
        .Write_Data_Master(Write_Data_Master),
        .Is_Master_Part_Of_Split(Is_Master_Part_Of_Split),
        .Write_Data_Finsh(finsh_b), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
        .S_WLAST(S_WLAST), .S_WVALID(S_WVALID), .S_WREADY(s_wready_b), .M_WDATA(m_wdata_b),
        .M_WSTRB(m_wstrb_b), .M_WLAST(m_wlast_b), .M_WVALID(m_wvalid_b), .M_WREADY(M_WREADY),
        .Split_Active(split_b), .Beat_Count(beat_count_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a queue head for one cycle; the DUT is in IDLE so it latches on this edge.
    task automatic grant(input int m, input logic sp);
        Master_Valid            = 1'b1;
        Write_Data_Master       = IW'(m);
        Is_Master_Part_Of_Split = sp;
        step();
        Master_Valid = 1'b0;
        exp_sel      = m;
        exp_sel_vld  = 1'b1;
        check("grant_split", 64'(Split_Active), 64'(sp));
        check("grant_count_clear", 64'(Beat_Count), 64'd0);
    endtask

    // Master m offers n beats back-to-back; each expected slave beat is queued when issued.
    task automatic send_burst(input int m, input int n, input logic [DW-1:0] base);
        beat_t bt;
        logic  acc;
        int    t;
        for (int b = 0; b < n; b++) begin
            bt.d = base + DW'(b);
            bt.s = SW'((b % 15) + 1);
            bt.l = (b == n - 1);
            exp_q.push_back(bt);
            S_WDATA[m*DW +: DW] = bt.d;
            S_WSTRB[m*SW +: SW] = bt.s;
            S_WLAST[m]          = bt.l;
            S_WVALID[m]         = 1'b1;
            t   = 0;
            acc = 1'b0;
            while (!acc && t < 50) begin
                @(negedge clk);
                acc = S_WREADY[m];
                step();
                t++;
            end
            if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
        end
        S_WVALID[m] = 1'b0;
        S_WLAST[m]  = 1'b0;
    endtask

    // Returns at the negedge where Finsh is seen (mid DONE cycle).
    task automatic wait_finsh();
        logic seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clk);
            seen = Write_Data_Finsh;
        end
        check("finsh_seen", 64'(seen), 64'd1);
        exp_sel_vld = 1'b0;
    endtask

    // Monitor: scoreboard pop on slave handshake, Finsh timing, backpressure hold, isolation.
    initial begin
        beat_t         e;
        logic          prev_last_hs = 1'b0;
        logic          prev_stall   = 1'b0;
        logic [DW-1:0] prev_data    = '0;
        logic [NM-1:0] mask;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_last_hs = 1'b0;
                prev_stall   = 1'b0;
            end else begin
                if (Write_Data_Finsh || prev_last_hs)
                    check("finsh_timing", 64'(Write_Data_Finsh), 64'(prev_last_hs));
                if (Write_Data_Finsh) fin_cnt++;
                if (prev_stall) begin
                    check("hold_data", 64'(M_WDATA), 64'(prev_data));
                    check("hold_valid", 64'(M_WVALID), 64'd1);
                end
                if (M_WVALID && !M_WREADY) check("stall_sready", 64'(S_WREADY), 64'd0);
                mask = '0;
                if (exp_sel_vld) mask[exp_sel] = 1'b1;
                if (S_WREADY != '0) check("sready_isolation", 64'(S_WREADY & ~mask), 64'd0);
                if (M_WVALID && M_WREADY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(M_WDATA), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(M_WDATA), 64'(e.d));
                        check("beat_strb", 64'(M_WSTRB), 64'(e.s));
                        check("beat_last", 64'(M_WLAST), 64'(e.l));
                    end
                end
                prev_last_hs = M_WVALID && M_WREADY && M_WLAST;
                prev_stall   = M_WVALID && !M_WREADY;
                prev_data    = M_WDATA;
            end
        end
    end

    initial begin
        int fin_base;
        reset                   = 1'b1;
        Master_Valid            = 1'b0;
        Write_Data_Master       = '0;
        Is_Master_Part_Of_Split = 1'b0;
        S_WDATA                 = '0;
        S_WSTRB                 = '0;
        S_WLAST                 = '0;
        S_WVALID                = '0;
        M_WREADY                = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_finsh", 64'(Write_Data_Finsh), 64'd0);
        check("rst_sready", 64'(S_WREADY), 64'd0);
        check("rst_mvalid", 64'(M_WVALID), 64'd0);
        check("rst_mdata", 64'(M_WDATA), 64'd0);
        check("rst_split", 64'(Split_Active), 64'd0);
        check("rst_count", 64'(Beat_Count), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();

        // Single 4-beat burst from master 1, full throughput.
        grant(1, 1'b0);
        send_burst(1, 4, 32'hA000_0000);
        wait_finsh();
        check("single_count", 64'(Beat_Count), 64'd4);
        check("single_count_sat", 64'(beat_count_b), 64'd3);
        step();

        // Slave backpressure for 3 cycles mid-burst.
        grant(1, 1'b1);
        fork
            send_burst(1, 4, 32'hB000_0010);
            begin
                repeat (2) step();
                M_WREADY = 1'b0;
                repeat (3) step();
                M_WREADY = 1'b1;
            end
        join
        wait_finsh();
        check("bp_count", 64'(Beat_Count), 64'd4);
        step();

        // Isolation: master 1 keeps valid high while master 0 owns the channel.
        S_WDATA[DW +: DW] = 32'hDEAD_BEEF;
        S_WLAST[1]        = 1'b1;
        S_WVALID[1]       = 1'b1;
        grant(0, 1'b0);
        send_burst(0, 2, 32'hC000_0000);
        wait_finsh();
        check("iso_count", 64'(Beat_Count), 64'd2);
        S_WVALID[1] = 1'b0;
        S_WLAST[1]  = 1'b0;
        step();

        // Out-of-range head index is ignored.
        Master_Valid      = 1'b1;
        Write_Data_Master = 2'd3;
        repeat (2) step();
        check("bad_idx_count_kept", 64'(Beat_Count), 64'd2);
        check("bad_idx_no_ready", 64'(S_WREADY), 64'd0);

        // Back-to-back heads 0 (split) then 1 (no split), head held through DONE.
        fin_base                = fin_cnt;
        Write_Data_Master       = 2'd0;
        Is_Master_Part_Of_Split = 1'b1;
        step();
        exp_sel     = 0;
        exp_sel_vld = 1'b1;
        check("b2b_split1", 64'(Split_Active), 64'd1);
        send_burst(0, 1, 32'hD000_0000);
        wait_finsh();
        Write_Data_Master       = 2'd1;
        Is_Master_Part_Of_Split = 1'b0;
        step();
        check("b2b_no_latch_in_done", 64'(Split_Active), 64'd1);
        step();
        Master_Valid = 1'b0;
        exp_sel      = 1;
        exp_sel_vld  = 1'b1;
        check("b2b_split2", 64'(Split_Active), 64'd0);
        send_burst(1, 1, 32'hD100_0000);
        wait_finsh();
        check("b2b_two_finsh", 64'(fin_cnt - fin_base), 64'd2);
        step();

        // Saturation: 6-beat burst on the 2-bit counter instance.
        grant(1, 1'b0);
        send_burst(1, 6, 32'hE000_0000);
        wait_finsh();
        check("sat_count_wide", 64'(Beat_Count), 64'd6);
        check("sat_count_narrow", 64'(beat_count_b), 64'd3);
        step();

        // Reset while a beat is stalled in the output stage.
        grant(0, 1'b1);
        M_WREADY = 1'b0;
        send_burst(0, 1, 32'hF000_0000);
        check("mid_mvalid_before", 64'(M_WVALID), 64'd1);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_sel_vld = 1'b0;
        check("mid_rst_mvalid", 64'(M_WVALID), 64'd0);
        check("mid_rst_sready", 64'(S_WREADY), 64'd0);
        check("mid_rst_count", 64'(Beat_Count), 64'd0);
        check("mid_rst_split", 64'(Split_Active), 64'd0);
        M_WREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        S_WVALID[0] = 1'b1;
        repeat (2) step();
        check("post_rst_idle_sready", 64'(S_WREADY), 64'd0);
        check("post_rst_idle_mvalid", 64'(M_WVALID), 64'd0);
        S_WVALID[0] = 1'b0;
        step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
